// File: rtl/moore_seq_detector.sv
// -----------------------------------------------------------------------------
// moore_seq_detector
//
// Moore-style serial sequence detector. One qualified bit is consumed per
// cycle. The last LEN bits are kept in a shift register together with a fill
// count. Match is decoded purely from registered state, so there is no
// combinational path from Din or DinValid to Match.
//
// Parameters:
//   LEN      pattern length in bits (2..16)
//   PATTERN  LEN-bit pattern, MSB is the first bit received
//   OVERLAP  1: matches may share bits; 0: bits of a match are not reused
//   CNT_W    match counter width (1..16)
//
// Build option:
//   SEQDET_COUNT_EN  when defined, a saturating match counter is built.
//                    When undefined, MatchCount and CountSat are tied to 0.
//
// Ports:
//   Clk         sole clock, rising edge
//   Reset_n     synchronous active-low reset (highest priority)
//   Clear       synchronous active-high soft clear (beats DinValid)
//   Din         serial data bit
//   DinValid    Din is sampled only when 1
//   Match       1 while the registered window equals PATTERN
//   Progress    fill count, 0..LEN
//   MatchCount  saturating number of matches
//   CountSat    MatchCount is all-ones
// -----------------------------------------------------------------------------
module moore_seq_detector #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Clear,
    input  logic                       Din,
    input  logic                       DinValid,
    output logic                       Match,
    output logic [$clog2(LEN+1)-1:0]   Progress,
    output logic [CNT_W-1:0]           MatchCount,
    output logic                       CountSat
);

    localparam int             FW    = $clog2(LEN + 1);
    localparam logic [FW-1:0]  LEN_F = FW'(LEN);

    logic [LEN-1:0] hist_reg;
    logic [LEN-1:0] hist_next;
    logic [FW-1:0]  fill_reg;
    logic [FW-1:0]  fill_next;
    logic [LEN-1:0] bit_eq;
    logic           zero_state;

    // Reset and clear share one effect; reset simply wins in priority.
    assign zero_state = !Reset_n || Clear;

    // Per-bit pattern comparison of the registered window.
    genvar gi;
    generate
        for (gi = 0; gi < LEN; gi++) begin : g_cmp
            assign bit_eq[gi] = (hist_reg[gi] == PATTERN[gi]);
        end
    endgenerate

    assign Match    = (fill_reg == LEN_F) && (&bit_eq);
    assign Progress = fill_reg;

    always_comb begin
        hist_next = hist_reg;
        fill_next = fill_reg;
        if (DinValid) begin
            hist_next = {hist_reg[LEN-2:0], Din};
            // In non-overlap mode the bit arriving while a match is shown
            // starts a fresh window, so the matched bits are not reused.
            if (!OVERLAP && Match) begin
                fill_next = FW'(1);
            end else if (fill_reg != LEN_F) begin
                fill_next = fill_reg + FW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (zero_state) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else begin
            hist_reg <= hist_next;
            fill_reg <= fill_next;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic             match_next;
    logic [CNT_W-1:0] cnt_reg;

    // Counting looks ahead at the state being loaded, so the count moves on
    // the same edge that makes Match rise (or keeps it high on overlaps).
    assign match_next = (fill_next == LEN_F) && (hist_next == PATTERN);

    always_ff @(posedge Clk) begin
        if (zero_state) begin
            cnt_reg <= '0;
        end else if (DinValid && match_next && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign MatchCount = cnt_reg;
    assign CountSat   = &cnt_reg;
`else
    assign MatchCount = '0;
    assign CountSat   = 1'b0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_detector
//
// Drives three detector instances (overlap, non-overlap, 2-bit counter) with
// the same stimulus and compares every output after each clock edge against a
// reference model. The model keeps the list of all valid bits received since
// the last clear/reset, plus per-instance the index where the current match
// window starts; matches are found by comparing the tail of that list to the
// pattern.
// -----------------------------------------------------------------------------
module tb_moore_seq_detector;

    localparam int       LEN = 4;
    localparam bit [3:0] PAT = 4'b1011;

    logic clk;
    logic reset_n;
    logic clear;
    logic din;
    logic din_valid;

    logic       match_a, match_b, match_c;
    logic [2:0] prog_a, prog_b, prog_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       sat_a, sat_b, sat_c;

    moore_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .Clk(clk), .Reset_n(reset_n), .Clear(clear), .Din(din), .DinValid(din_valid),
        .Match(match_a), .Progress(prog_a), .MatchCount(cnt_a), .CountSat(sat_a)
    );

    moore_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .Clk(clk), .Reset_n(reset_n), .Clear(clear), .Din(din), .DinValid(din_valid),
        .Match(match_b), .Progress(prog_b), .MatchCount(cnt_b), .CountSat(sat_b)
    );

    moore_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .Clk(clk), .Reset_n(reset_n), .Clear(clear), .Din(din), .DinValid(din_valid),
        .Match(match_c), .Progress(prog_c), .MatchCount(cnt_c), .CountSat(sat_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit bits_q[$];
    int win_start[3];
    int cnt_m[3];
    bit overlap_m[3] = '{1'b1, 1'b0, 1'b1};
    int cnt_max[3]   = '{255, 255, 3};

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic bit model_match(input int i);
        int n;
        n = bits_q.size();
        if (n - win_start[i] < LEN) return 1'b0;
        for (int k = 0; k < LEN; k++) begin
            if (bits_q[n - LEN + k] != PAT[LEN - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int model_progress(input int i);
        int f;
        f = bits_q.size() - win_start[i];
        return (f > LEN) ? LEN : f;
    endfunction

    function automatic int model_count(input int i);
`ifdef SEQDET_COUNT_EN
        return cnt_m[i];
`else
        return 0 * i;
`endif
    endfunction

    function automatic int model_sat(input int i);
`ifdef SEQDET_COUNT_EN
        return (cnt_m[i] == cnt_max[i]) ? 1 : 0;
`else
        return 0 * i;
`endif
    endfunction

    // One transaction: apply inputs for one clock, update the model, check.
    task automatic step(input bit rst_n, input bit clr, input bit v, input bit d);
        bit cur_m[3];
        reset_n   = rst_n;
        clear     = clr;
        din_valid = v;
        din       = d;
        @(posedge clk);
        if (!rst_n || clr) begin
            bits_q.delete();
            for (int i = 0; i < 3; i++) begin
                win_start[i] = 0;
                cnt_m[i]     = 0;
            end
        end else if (v) begin
            for (int i = 0; i < 3; i++) cur_m[i] = model_match(i);
            bits_q.push_back(d);
            for (int i = 0; i < 3; i++) begin
                if (!overlap_m[i] && cur_m[i]) win_start[i] = bits_q.size() - 1;
                if (model_match(i) && cnt_m[i] < cnt_max[i]) cnt_m[i]++;
            end
        end
        #1;
        $display("txn rst_n=%0b clr=%0b v=%0b d=%0b | A m=%0b p=%0d c=%0d | B m=%0b p=%0d c=%0d | C m=%0b p=%0d c=%0d s=%0b",
                 rst_n, clr, v, d, match_a, prog_a, cnt_a, match_b, prog_b, cnt_b,
                 match_c, prog_c, cnt_c, sat_c);
        check_val("a_match", int'(match_a), int'(model_match(0)));
        check_val("a_prog",  int'(prog_a),  model_progress(0));
        check_val("a_cnt",   int'(cnt_a),   model_count(0));
        check_val("a_sat",   int'(sat_a),   model_sat(0));
        check_val("b_match", int'(match_b), int'(model_match(1)));
        check_val("b_prog",  int'(prog_b),  model_progress(1));
        check_val("b_cnt",   int'(cnt_b),   model_count(1));
        check_val("b_sat",   int'(sat_b),   model_sat(1));
        check_val("c_match", int'(match_c), int'(model_match(2)));
        check_val("c_prog",  int'(prog_c),  model_progress(2));
        check_val("c_cnt",   int'(cnt_c),   model_count(2));
        check_val("c_sat",   int'(sat_c),   model_sat(2));
    endtask

    task automatic send_bits(input bit [31:0] seq, input int n);
        for (int k = n - 1; k >= 0; k--) step(1'b1, 1'b0, 1'b1, seq[k]);
    endtask

    initial begin
        reset_n   = 1'b0;
        clear     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;

        // Reset state, with data offered during reset
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);

        // Stream 1,0,1,1,0,1,1: overlap matches twice, non-overlap once
        send_bits(32'b1011011, 7);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Gap during partial pattern
        step(1'b1, 1'b1, 1'b0, 1'b0);
        send_bits(32'b10, 2);
        for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(32'b11, 2);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Saturation of the 2-bit counter: pattern repeated 5 times
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 5; r++) send_bits(32'b1011, 4);

        // Reset mid-pattern
        step(1'b1, 1'b1, 1'b0, 1'b0);
        send_bits(32'b101, 3);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_bits(32'b1, 1);

        // Clear and valid together after a match; the bit is discarded
        step(1'b1, 1'b1, 1'b0, 1'b0);
        send_bits(32'b1011, 4);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 1500; t++) begin
            bit r_rst, r_clr, r_v, r_d;
            r_rst = ($urandom_range(0, 199) == 0);
            r_clr = ($urandom_range(0, 79) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_d   = ($urandom_range(0, 2) != 0);
            step(!r_rst, r_clr, r_v, r_d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised Moore-style serial sequence detector, the successor to the Lab2 fixed 4-bit state decoder. It consumes one qualified bit per cycle, tracks match progress in registered state, and raises `Match` purely from that state. It adds configurable pattern length and value, overlap and non-overlap modes, input qualification, and an optional saturating match counter. It sits behind any serial bit source in the lab datapath and drives LEDs or a downstream controller.

## Interface
- `LEN`, default 4: pattern length in bits, legal range 2..16.
- `PATTERN`, default 4'b1011: `LEN`-bit pattern; MSB is the first bit received.
- `OVERLAP`, default 1: 1 lets matches share bits; 0 means bits used by a match are not reused.
- `CNT_W`, default 8: match counter width, legal range 1..16.
- `Clk`, input, 1: sole clock; all state changes on the rising edge.
- `Reset_n`, input, 1: synchronous, active-low reset.
- `Clear`, input, 1: synchronous, active-high soft clear.
- `Din`, input, 1: serial data bit.
- `DinValid`, input, 1: `Din` is sampled only when this is 1.
- `Match`, output, 1: Moore output; 1 while the current state is a completed match.
- `Progress`, output, $clog2(LEN+1): fill count, 0..LEN.
- `MatchCount`, output, CNT_W: number of matches; saturating.
- `CountSat`, output, 1: `MatchCount` has reached all-ones.

## Operation
- State registers:
  - `Hist[LEN-1:0]` holds the received bits, newest in bit 0.
  - `Fill` counts valid bits, 0..LEN.
  - `Cnt[CNT_W-1:0]` is the match counter.
- `Match = (Fill == LEN) && (Hist == PATTERN)`. It is decoded from registered state only; there is no combinational path from `Din` or `DinValid`.
- `Progress = Fill`.
- When `DinValid=1`:
  - `Hist <= {Hist[LEN-2:0], Din}`.
  - Normally `Fill <= min(Fill+1, LEN)`.
  - If `OVERLAP=0` and `Match=1` in the current cycle, `Fill <= 1` instead. The new bit becomes the first bit of the next window.
- When `DinValid=0`: all state holds, including `Match`.
- Counting: `Cnt` increments on any edge where `DinValid=1` and the next state satisfies the match condition.
  - It saturates at 2^CNT_W−1 and never wraps.
  - `CountSat = (Cnt == all-ones)`.
- `Clear=1`: `Hist`, `Fill` and `Cnt` go to 0 on the next edge. `Clear` takes priority over `DinValid`, and the bit presented in that cycle is discarded.
- Reset (`Reset_n=0`) has the same effect as `Clear` and takes priority over both `Clear` and `DinValid`.
- Reset values: `Match=0`, `Progress=0`, `MatchCount=0`, `CountSat=0`.

## Timing
- Latency: `Match` rises in the cycle after the edge that samples the final pattern bit (1 cycle).
- `Match` stays high until the next valid bit, `Clear` or reset.
- Back-to-back overlapping matches keep `Match` high across consecutive cycles, and `Cnt` increments on each of those edges.
- Reset or clear mid-pattern: `Progress` is 0 in the following cycle. Any partial match is lost and no spurious `Match` follows.
- Gaps in `DinValid` of any length do not affect detection.

## Configuration
- `SEQDET_COUNT_EN`:
  - Defined: `Cnt` is built, and `MatchCount` and `CountSat` behave as described above.
  - Undefined: no counter registers are built; `MatchCount` is tied to 0 and `CountSat` is tied to 0.
- `Match` and `Progress` behaviour is identical in both builds.

## Test plan
All scenarios use the default parameters (`LEN=4`, `PATTERN=1011`) with `SEQDET_COUNT_EN` defined, unless stated otherwise.
- `OVERLAP=1`, `DinValid=1` continuously, stream 1,0,1,1,0,1,1 -> `Match` high one cycle after bit 4 and again one cycle after bit 7; `MatchCount=2`.
- `OVERLAP=0`, same stream -> `Match` high only after bit 4; `Progress` reads 1, 2, 3 after bits 5–7; `MatchCount=1`.
- Stream 1,0 followed by 3 cycles of `DinValid=0`, then 1,1 -> `Progress` holds at 2 during the gap; `Match` rises one cycle after the last bit.
- `CNT_W=2`, `OVERLAP=1`, stream 1,0,1,1 repeated 5 times -> `MatchCount` stops at 3; `CountSat=1`; no wrap.
- Stream 1,0,1, then `Reset_n=0` for one cycle, then 1 -> `Progress` reads 0 and then 1; `Match` stays 0.
- After one match, assert `Clear=1` and `DinValid=1` in the same cycle -> `Progress=0`, `Match=0`, `MatchCount=0`; the bit presented in that cycle is ignored.
